// File: rtl/burst_ram_pkg.sv
// Shared encodings for the BurstRAM arbiter: command codes, FSM states and owner ids.
package burst_ram_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StXfer,
    StDrain
  } state_e;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } owner_e;

endpackage

// File: rtl/burst_ram_beat_counter.sv
// Beat counter for one burst; flags the final beat (Count-1) of the transfer.
module burst_ram_beat_counter #(
  parameter int unsigned Count = 4,
  parameter int unsigned CntW  = $clog2(Count)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] preset,
  input  logic            inc,
  output logic            last
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= preset;
    end else if (inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CntW'(Count - 1));

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares the BurstRAM port between icache (read-only) and dcache, granting whole bursts
// with round-robin arbitration and routing write data / read strobes to the owner only.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
  parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
  parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_i,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        addr_i,
  output logic                                 gnt_i,
  output logic                                 rd_valid_i,
  output logic                                 done_i,
  input  logic                                 req_d,
  input  logic                                 cmd_d,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        addr_d,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   wr_data_d,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] mask_d,
  output logic                                 gnt_d,
  output logic                                 rd_valid_d,
  output logic                                 done_d,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int unsigned CntW = $clog2(RAM_BURST_DATA_COUNT);

  state_e                        state_q;
  owner_e                        owner_q;
  owner_e                        last_grant_q;
  logic                          cmd_q;
  logic [RAM_DEPTH_BITWIDTH-1:0] addr_q;

  owner_e                        pick;
  logic                          pick_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] pick_addr;
  logic                          grant_now;
  logic                          active;
  logic                          wr_path;
  logic                          beat_done;
  logic                          last_beat;
  logic [CntW-1:0]               preset_val;

  // On a tie the requester that did not win last time gets the port.
  assign pick      = (req_d && (!req_i || last_grant_q == OWNER_I)) ? OWNER_D : OWNER_I;
  assign pick_cmd  = (pick == OWNER_D) ? cmd_d : CMD_READ;
  assign pick_addr = (pick == OWNER_D) ? addr_d : addr_i;
  assign grant_now = (state_q == StIdle) && !br_busy && (req_i || req_d);

  assign active  = (state_q == StIssue) || (state_q == StXfer);
  assign wr_path = active && (owner_q == OWNER_D) && (cmd_q == CMD_WRITE);

  // Writes send beat 0 during ISSUE, so the counter starts at 1 and steps only in XFER.
  assign beat_done  = active && ((cmd_q == CMD_WRITE) ? (state_q == StXfer) : br_rd_data_valid);
  assign preset_val = (pick_cmd == CMD_WRITE) ? CntW'(1) : '0;

  burst_ram_beat_counter #(
    .Count(RAM_BURST_DATA_COUNT),
    .CntW (CntW)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_now),
    .preset(preset_val),
    .inc   (beat_done),
    .last  (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OWNER_I;
      last_grant_q <= OWNER_D;
      cmd_q        <= CMD_READ;
      addr_q       <= '0;
      gnt_i        <= 1'b0;
      gnt_d        <= 1'b0;
      done_i       <= 1'b0;
      done_d       <= 1'b0;
    end else begin
      gnt_i  <= 1'b0;
      gnt_d  <= 1'b0;
      done_i <= 1'b0;
      done_d <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_now) begin
            owner_q      <= pick;
            last_grant_q <= pick;
            cmd_q        <= pick_cmd;
            addr_q       <= pick_addr;
            gnt_i        <= (pick == OWNER_I);
            gnt_d        <= (pick == OWNER_D);
            state_q      <= StIssue;
          end
        end
        StIssue: state_q <= StXfer;
        StXfer: begin
          if (beat_done && last_beat) state_q <= StDrain;
        end
        StDrain: begin
          if (!br_busy) begin
            done_i  <= (owner_q == OWNER_I);
            done_d  <= (owner_q == OWNER_D);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Command outputs decode registered state only, so they are glitch-free.
  assign br_cmd_en    = (state_q == StIssue);
  assign br_cmd       = (state_q == StIssue) ? cmd_q : CMD_READ;
  assign br_addr      = (state_q == StIssue) ? addr_q : '0;
  assign br_wr_data   = wr_path ? wr_data_d : '0;
  assign br_data_mask = wr_path ? mask_d : '0;
  assign rd_valid_i   = active && (owner_q == OWNER_I) && br_rd_data_valid;
  assign rd_valid_d   = active && (owner_q == OWNER_D) && br_rd_data_valid;
  assign rd_data      = br_rd_data;

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares the single BurstRAM command/data port between the instruction cache (read-only requester "i") and the data cache (read/write requester "d").
- Grants whole bursts: one command plus RAM_BURST_DATA_COUNT data beats.
- Routes write data from the owner and read-valid strobes to the owner only.
- Replaces the ad-hoc br_* muxing in the cache top; sits between both caches and BurstRAM.

Parameters:
- RAM_DEPTH_BITWIDTH, 4: BurstRAM address width; must match BurstRAM.
- RAM_BURST_DATA_BITWIDTH, 64: width of one burst beat in bits; divisible by 8.
- RAM_BURST_DATA_COUNT, 4: beats per burst; at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  icache requests a read burst; held until gnt_i
- addr_i  in  RAM_DEPTH_BITWIDTH  icache burst address
- gnt_i  out  1  pulse: icache burst issued this cycle
- rd_valid_i  out  1  br_rd_data_valid gated to icache
- done_i  out  1  pulse: icache burst complete
- req_d  in  1  dcache requests a burst; held until gnt_d
- cmd_d  in  1  0 = read, 1 = write
- addr_d  in  RAM_DEPTH_BITWIDTH  dcache burst address
- wr_data_d  in  RAM_BURST_DATA_BITWIDTH  write beat from dcache
- mask_d  in  RAM_BURST_DATA_BITWIDTH/8  byte mask from dcache
- gnt_d  out  1  pulse: dcache burst issued; write beat 0 is sampled this cycle
- rd_valid_d  out  1  br_rd_data_valid gated to dcache
- done_d  out  1  pulse: dcache burst complete
- rd_data  out  RAM_BURST_DATA_BITWIDTH  br_rd_data broadcast to both requesters
- br_cmd  out  1  BurstRAM command
- br_cmd_en  out  1  BurstRAM command strobe
- br_addr  out  RAM_DEPTH_BITWIDTH  BurstRAM address
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  BurstRAM write data
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  BurstRAM byte mask
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  BurstRAM read data
- br_rd_data_valid  in  1  BurstRAM read beat strobe
- br_busy  in  1  BurstRAM busy

Behaviour:
- States: IDLE, ISSUE, XFER, DRAIN. Registers: owner (I/D), cmd_q, addr_q, beat_cnt, last_grant.
- Reset: state=IDLE, last_grant=D (so i wins the first tie). All outputs 0: gnt_*, done_*, rd_valid_*, br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask.
- Reset mid-burst: returns to IDLE next edge with no done pulse; BurstRAM state is the system's concern.
- IDLE:
  - If br_busy=0 and any req, pick the owner. A single requester wins outright. If both request, the winner is the one != last_grant.
  - Latch addr_q and cmd_q (i forces read), update last_grant, go to ISSUE.
  - If br_busy=1, hold.
- ISSUE (exactly 1 cycle):
  - br_cmd_en=1, br_cmd=cmd_q, br_addr=addr_q, gnt_owner=1.
  - Write: beat 0 = wr_data_d/mask_d this cycle; beat_cnt=1.
  - Read: beat_cnt=0.
  - Go to XFER.
- Latency: req sampled in IDLE at cycle N (with br_busy=0) -> br_cmd_en and gnt at N+1.
- XFER, write:
  - One beat per cycle; beat_cnt increments every cycle.
  - Leave after beat COUNT-1, i.e. COUNT cycles total counting ISSUE.
- XFER, read:
  - Count br_rd_data_valid beats; leave when beat COUNT-1 is seen. No timeout.
- Write data path:
  - br_wr_data/br_data_mask pass wr_data_d/mask_d combinationally while owner=D, cmd_q=write and state is ISSUE or XFER.
  - Otherwise br_wr_data=0 and br_data_mask=0.
- Read-valid routing:
  - rd_valid_owner = br_rd_data_valid during ISSUE/XFER; the non-owner always sees 0.
  - br_rd_data_valid in IDLE/DRAIN is ignored.
  - rd_data is an unregistered passthrough.
- DRAIN:
  - Wait for br_busy=0, then pulse done_owner for 1 cycle and go to IDLE.
  - Back-to-back grant is possible the cycle after done.
- Request rules:
  - A req dropped before grant is simply not served.
  - req held after done is re-arbitrated; round-robin prevents starvation.
  - cmd_d, addr_d and addr_i are sampled only at grant.

Decomposition:
- Package burst_ram_pkg holds:
  - CMD_READ=0, CMD_WRITE=1
  - state encoding for IDLE/ISSUE/XFER/DRAIN
  - owner encoding OWNER_I/OWNER_D
- Optional sub-module burst_ram_beat_counter:
  - inputs: load, inc, preset value
  - output: last-beat flag at COUNT-1
  - width $clog2(RAM_BURST_DATA_COUNT)

Test Plan:
- Reset then req_i=1, addr_i=3, br_busy=0:
  - br_cmd_en=1, br_cmd=0, br_addr=3 and gnt_i one cycle later.
  - 4 valid beats appear only on rd_valid_i; rd_valid_d=0.
  - done_i after br_busy falls.
- req_d write, addr_d=5, wr_data_d=beat k (k=0..3) from the gnt_d cycle:
  - br_wr_data carries the 4 beats over 4 consecutive cycles with mask_d.
  - done_d after drain.
- req_i and req_d asserted simultaneously, both held:
  - grants alternate i, d, i, d; neither port waits more than one burst.
- br_busy=1 held while req_d=1: no br_cmd_en; grant issued the cycle after br_busy falls.
- Read burst for i with valid beats spaced by idle cycles:
  - arbiter stays in XFER until the 4th beat.
  - A concurrent req_d is not granted until after done_i.
- rst asserted during XFER:
  - next cycle all outputs 0, state IDLE, no done.
  - A pending req_i is granted first, since last_grant is reset to D.
